// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide unit with architectural Hi/Lo registers.
// MULT is a radix-2 Booth multiplier. DIV is restoring division on magnitudes, followed by a sign fix-up.
module mult_div_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mult_start,
  input  logic        div_start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Hiout,
  output logic [31:0] Loout,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [4:0]  count;
  logic        last_iter;

  logic [31:0] mcand;
  logic [64:0] acc;
  logic [32:0] booth_hi;
  logic [32:0] booth_sum;
  logic [64:0] acc_next;

  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        q_neg;
  logic        r_neg;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic        div_fits;
  logic [31:0] rem_next;
  logic [31:0] quo_next;
  logic [31:0] hi_fix;
  logic [31:0] lo_fix;

  assign last_iter = (count == 5'd31);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (mult_start) begin
          state_next = S_MULT;
        end else if (div_start) begin
          state_next = (B == 32'd0) ? S_DONE : S_DIV;
        end
      end
      S_MULT:  if (last_iter) state_next = S_DONE;
      S_DIV:   if (last_iter) state_next = S_FIX;
      S_FIX:   state_next = S_DONE;
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The upper half is one bit wider than the operands, so that A = -2^31 stays exact in the Booth add/sub.
  always_comb begin
    booth_hi = {acc[64], acc[64:33]};
    case (acc[1:0])
      2'b01:   booth_sum = booth_hi + {mcand[31], mcand};
      2'b10:   booth_sum = booth_hi - {mcand[31], mcand};
      default: booth_sum = booth_hi;
    endcase
    acc_next = {booth_sum, acc[32:1]};
  end

  always_comb begin
    div_shift = {rem, quo[31]};
    div_fits  = (div_shift >= {1'b0, dvs});
    div_diff  = div_shift - {1'b0, dvs};
    rem_next  = div_fits ? div_diff[31:0] : div_shift[31:0];
    quo_next  = {quo[30:0], div_fits};
    lo_fix    = q_neg ? (32'd0 - quo) : quo;
    hi_fix    = r_neg ? (32'd0 - rem) : rem;
  end

  // Hi/Lo change only when DONE is entered with a real result, never mid-computation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count    <= 5'd0;
      mcand    <= 32'd0;
      acc      <= 65'd0;
      rem      <= 32'd0;
      quo      <= 32'd0;
      dvs      <= 32'd0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      Hiout    <= 32'd0;
      Loout    <= 32'd0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (mult_start) begin
            mcand    <= A;
            acc      <= {32'd0, B, 1'b0};
            count    <= 5'd0;
            div_zero <= 1'b0;
          end else if (div_start) begin
            rem      <= 32'd0;
            quo      <= A[31] ? (32'd0 - A) : A;
            dvs      <= B[31] ? (32'd0 - B) : B;
            q_neg    <= A[31] ^ B[31];
            r_neg    <= A[31];
            count    <= 5'd0;
            div_zero <= (B == 32'd0);
          end
        end
        S_MULT: begin
          acc   <= acc_next;
          count <= count + 5'd1;
          if (last_iter) begin
            Hiout <= acc_next[64:33];
            Loout <= acc_next[32:1];
          end
        end
        S_DIV: begin
          rem   <= rem_next;
          quo   <= quo_next;
          count <= count + 5'd1;
        end
        S_FIX: begin
          Hiout <= hi_fix;
          Loout <= lo_fix;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
